// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the memory stage
package cpu_pkg;

   localparam int DATA_W          = 16;
   localparam int TIMEOUT_DEFAULT = 15;
   localparam int CNT_W           = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_e;

endpackage

// File: rtl/memwb_register.sv
// rtl/memwb_register.sv - MemoryWriteback pipeline register with bubble insert
module memwb_register
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              bubble_in,
   input  logic              wbs_in,
   input  logic              wme_in,
   input  logic              ni_in,
   input  logic [DATA_W-1:0] alu_in,
   input  logic [DATA_W-1:0] rdata_in,
   output logic              wbs_out,
   output logic              wme_out,
   output logic              ni_out,
   output logic [DATA_W-1:0] alu_out,
   output logic [DATA_W-1:0] rdata_out
);

   logic              wbs_q, wbs_d;
   logic              wme_q, wme_d;
   logic              ni_q, ni_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // Next contents: the incoming instruction, or an empty slot while the stage stalls
   always_comb begin
      wbs_d   = wbs_in;
      wme_d   = wme_in;
      ni_d    = ni_in;
      alu_d   = alu_in;
      rdata_d = rdata_in;
      if (bubble_in) begin
         wbs_d   = 1'b0;
         wme_d   = 1'b0;
         ni_d    = 1'b1;
         alu_d   = '0;
         rdata_d = '0;
      end
   end

   // Register loads every cycle; reset leaves a bubble in the slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbs_q   <= 1'b0;
         wme_q   <= 1'b0;
         ni_q    <= 1'b1;
         alu_q   <= '0;
         rdata_q <= '0;
      end else begin
         wbs_q   <= wbs_d;
         wme_q   <= wme_d;
         ni_q    <= ni_d;
         alu_q   <= alu_d;
         rdata_q <= rdata_d;
      end
   end

   assign wbs_out   = wbs_q;
   assign wme_out   = wme_q;
   assign ni_out    = ni_q;
   assign alu_out   = alu_q;
   assign rdata_out = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline memory stage with data-memory handshake and timeout
module memory_stage
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wbs_in,
   input  logic              wme_in,
   input  logic              mm_in,
   input  logic              wm_in,
   input  logic              ni_in,
   input  logic [DATA_W-1:0] ALUresult_in,
   input  logic [DATA_W-1:0] memData_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_out,
   output logic              wbs_out,
   output logic              wme_out,
   output logic              ni_out,
   output logic [DATA_W-1:0] ALUresult_out,
   output logic [DATA_W-1:0] readData_out,
   output logic              err_out
);

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;

   logic              access;
   logic              in_access;
   logic              timeout;
   logic              stall;
   logic [DATA_W-1:0] wb_rdata;

   // Handshake decode; mem_ack only matters while a transaction is open
   always_comb begin
      access    = (mm_in | wm_in) & ~ni_in;
      in_access = (state_q == ACCESS);
      timeout   = in_access & (cnt_q == CNT_W'(TIMEOUT - 1)) & ~mem_ack;
      stall     = (~in_access & access) | (in_access & ~mem_ack & ~timeout);
      wb_rdata  = (in_access & mem_ack & ~we_q) ? mem_rdata : '0;
   end

   // Transaction FSM: capture request on entry, hold it, release on ack or timeout
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (access) begin
               state_d = ACCESS;
               cnt_d   = '0;
               req_d   = 1'b1;
               we_d    = wm_in;
               addr_d  = ALUresult_in;
               wdata_d = memData_in;
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            if (mem_ack || timeout) begin
               state_d = IDLE;
               req_d   = 1'b0;
               we_d    = 1'b0;
            end
            if (timeout) begin
               err_d = 1'b1;
            end
         end
      endcase
   end

   // State and request registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   // Upstream holds the instruction during a stall, so its fields are still valid on exit
   memwb_register u_memwb (
      .clk       (clk),
      .rst       (rst),
      .bubble_in (stall),
      .wbs_in    (wbs_in),
      .wme_in    (wme_in),
      .ni_in     (ni_in),
      .alu_in    (ALUresult_in),
      .rdata_in  (wb_rdata),
      .wbs_out   (wbs_out),
      .wme_out   (wme_out),
      .ni_out    (ni_out),
      .alu_out   (ALUresult_out),
      .rdata_out (readData_out)
   );

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign stall_out = stall;
   assign err_out   = err_q;

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning ACCESS cycles without mem_ack before forced completion.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 wbs_in, wme_in  in  1 each  writeback source select / register write enable from ExecuteMemory register.
REQ-006 mm_in  in  1  load request.
REQ-007 wm_in  in  1  store request.
REQ-008 ni_in  in  1  bubble flag; 1 = no instruction.
REQ-009 ALUresult_in, memData_in  in  16 each  address/ALU value, store data.
REQ-010 mem_req, mem_we  out  1 each  data-memory request, write strobe.
REQ-011 mem_addr, mem_wdata  out  16 each  data-memory address, write data.
REQ-012 mem_rdata  in  16; mem_ack  in  1  memory read data, completion.
REQ-013 stall_out  out  1  hold ExecuteMemory and all earlier stages.
REQ-014 wbs_out, wme_out, ni_out  out  1 each  MemoryWriteback register copies.
REQ-015 ALUresult_out, readData_out  out  16 each  MemoryWriteback data.
REQ-016 err_out  out  1  sticky timeout flag.

Function
REQ-017 access = (mm_in | wm_in) & ~ni_in; wm_in has priority when both set (store; readData_out = 0).
REQ-018 FSM states IDLE, ACCESS; IDLE->ACCESS on edge when access=1; ACCESS->IDLE on edge when mem_ack=1 or timeout.
REQ-019 Entering ACCESS, mem_addr <= ALUresult_in, mem_wdata <= memData_in, mem_we <= wm_in, mem_req <= 1; all four held constant while in ACCESS.
REQ-020 mem_req SHALL be 1 exactly in ACCESS, dropping on the edge leaving ACCESS.
REQ-021 stall_out = (IDLE & access) | (ACCESS & ~mem_ack & ~timeout), combinational.
REQ-022 Non-access instruction: MemoryWriteback outputs load inputs on next edge (1-cycle latency), readData_out = 0.
REQ-023 Access instruction: MemoryWriteback loads on the ACCESS-exit edge, readData_out = mem_rdata (load with ack), 0 otherwise; minimum latency 2 cycles.
REQ-024 While stall_out=1, MemoryWriteback loads a bubble: ni_out=1, wme_out=0, others 0.
REQ-025 4-bit cycle counter clears on ACCESS entry, increments each ACCESS cycle; timeout = (count == TIMEOUT-1) & ~mem_ack.
REQ-026 On timeout: complete instruction with readData_out = 0, set err_out=1; err_out clears only on rst.
REQ-027 mem_ack outside ACCESS SHALL be ignored.
REQ-028 mem_ack and timeout in the same cycle: ack wins, err_out unchanged.
REQ-029 Back-to-back accesses: ACCESS->IDLE->ACCESS, one IDLE cycle between requests.

Reset
REQ-030 rst asynchronously forces IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0, err_out=0.
REQ-031 rst forces ni_out=1, wbs_out=0, wme_out=0, ALUresult_out=0, readData_out=0.
REQ-032 rst mid-ACCESS abandons the transaction; late mem_ack after release is ignored (REQ-027).

Structure
REQ-033 cpu_pkg holds the state enum, DATA_W=16 and the default TIMEOUT constant.
REQ-034 MemoryWriteback pipeline register is a sub-module memwb_register with bubble-insert input.

Verification
REQ-035 ALU op, ni_in=0, mm=wm=0, ALUresult_in=16'h0005, wme_in=1 -> next edge ALUresult_out=0005, wme_out=1, stall_out never 1.
REQ-036 Load addr 16'h0010, mem_ack 3 cycles after mem_req, mem_rdata=16'hBEEF -> mem_addr=0010, readData_out=BEEF, stall_out high 4 cycles, bubbles meanwhile.
REQ-037 Store addr 16'h0020, data 16'h1234, ack after 1 cycle -> mem_we=1, mem_wdata=1234, readData_out=0.
REQ-038 Load with no ack -> mem_req drops after 15 cycles, err_out=1 persists, readData_out=0, pipeline resumes.
REQ-039 rst pulse during ACCESS -> mem_req=0 immediately, ni_out=1; later mem_ack produces no writeback.
REQ-040 Two consecutive loads, immediate ack each -> two mem_req pulses separated by one low cycle, both results in order.
